hms_display_scanner: RTL and testbench

- Display-side reader for the six BCD digit registers of the 12-hour clock.
- Takes the packed 24-bit time word {HHB,LHB,HMB,LMB,HSB,LSB} and the control state code.
- Time-multiplexes the digits onto a common-anode six-digit seven-segment display, with a colon, leading-zero blanking and set-mode blinking.
- Snapshots the time word once per scan frame so a carry ripple (e.g. 12:59:59 -> 01:00:00) never appears torn.

---
 rtl/hms_display_scanner.sv | 112 +++++++++++
 tb/tb_hms_display_scanner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hms_display_scanner.sv
// Six-digit common-anode seven-segment scanner for the 12-hour BCD clock.
// Snapshots the time word once per scan frame; adds colon, leading-zero blanking and set-mode blink.
module hms_display_scanner #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] currentBits,
   input  logic [3:0]  state,
   output logic [5:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frameDone
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0] presc;
   logic [2:0]    idx;
   logic [23:0]   shadow;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   logic          tc;
   logic          wrap;
   logic          blink_last;
   logic [3:0]    digit;
   logic [5:0]    an_next;
   logic [6:0]    seg_next;
   logic          dp_next;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b0111111;
      endcase
   endfunction

   assign tc         = (presc == PW'(SCAN_DIV - 1));
   assign wrap       = tc && (idx == 3'd5);
   assign blink_last = (blink_cnt == BW'(BLINK_FRAMES - 1));

   always_comb begin
      digit = 4'd0;
      case (idx)
         3'd0:    digit = shadow[3:0];
         3'd1:    digit = shadow[7:4];
         3'd2:    digit = shadow[11:8];
         3'd3:    digit = shadow[15:12];
         3'd4:    digit = shadow[19:16];
         3'd5:    digit = shadow[23:20];
         default: digit = 4'd0;
      endcase

      seg_next = seg_decode(digit);

      // Leading-zero hour and the dark half of the set-mode blink both blank the anode.
      an_next = ~(6'b000001 << idx);
      if (((idx == 3'd5) && (digit == 4'd0)) || ((state == 4'd1) && blink_phase))
         an_next = 6'b111111;

      // Colon only flashes in run mode; reset, set and unknown states hold it on.
      dp_next = 1'b1;
      if (((idx == 3'd2) || (idx == 3'd4)) && !((state == 4'd3) && blink_phase))
         dp_next = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc       <= '0;
         idx         <= 3'd0;
         shadow      <= 24'h000000;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         an          <= 6'b111111;
         seg         <= 7'h7F;
         dp          <= 1'b1;
         frameDone   <= 1'b0;
      end else begin
         presc <= tc ? '0 : presc + PW'(1);
         if (tc)
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;

         frameDone <= wrap;
         if (wrap) begin
            shadow <= currentBits;
            if (blink_last) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + BW'(1);
            end
         end

         an  <= an_next;
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_hms_display_scanner.sv
// Directed bench for hms_display_scanner: per-frame expected digits are queued and popped as the scan shows them.
module tb_hms_display_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int BLINK_FRAMES = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] currentBits;
   logic [3:0]  state;
   logic [5:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frameDone;

   always #5 clk = ~clk;

   hms_display_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .currentBits (currentBits),
      .state       (state),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frameDone   (frameDone)
   );

   typedef struct packed {
      logic [5:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;
   int   frames = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      case (d)
         4'd0:    ref_seg = 7'b1000000;
         4'd1:    ref_seg = 7'b1111001;
         4'd2:    ref_seg = 7'b0100100;
         4'd3:    ref_seg = 7'b0110000;
         4'd4:    ref_seg = 7'b0011001;
         4'd5:    ref_seg = 7'b0010010;
         4'd6:    ref_seg = 7'b0000010;
         4'd7:    ref_seg = 7'b1111000;
         4'd8:    ref_seg = 7'b0000000;
         4'd9:    ref_seg = 7'b0010000;
         default: ref_seg = 7'b0111111;
      endcase
   endfunction

   function automatic exp_t ref_digit(input logic [23:0] w, input int k,
                                      input logic [3:0] st, input logic ph);
      exp_t       e;
      logic [3:0] d;
      d     = 4'(w >> (4 * k));
      e.seg = ref_seg(d);
      e.an  = 6'b111111;
      if (!((k == 5) && (d == 4'd0)) && !((st == 4'd1) && ph))
         e.an[k] = 1'b0;
      e.dp = 1'b1;
      if (((k == 2) || (k == 4)) && !((st == 4'd3) && ph))
         e.dp = 1'b0;
      return e;
   endfunction

   // One full frame: optionally sync to frameDone, queue six expected digits, then check 24 cycles.
   task automatic run_frame(input logic sync, input logic [23:0] w,
                            input int chg_at, input logic [23:0] chg_w);
      exp_t e;
      logic ph;
      int   n;
      e = '0;
      if (sync) begin
         n = 0;
         while (frameDone !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("frame_sync", 32'(frameDone), 32'd1);
         frames++;
      end
      ph = ((frames / 2) % 2) != 0;
      for (int k = 0; k < 6; k++)
         sb.push_back(ref_digit(w, k, state, ph));
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i == chg_at)
            currentBits = chg_w;
         if (i % 4 == 0)
            e = sb.pop_front();
         chk($sformatf("an_f%0d_d%0d", frames, i / 4), 32'(an), 32'(e.an));
         chk($sformatf("seg_f%0d_d%0d", frames, i / 4), 32'(seg), 32'(e.seg));
         chk($sformatf("dp_f%0d_d%0d", frames, i / 4), 32'(dp), 32'(e.dp));
         chk($sformatf("frameDone_f%0d_c%0d", frames, i), 32'(frameDone), 32'(i == 23));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      currentBits = 24'h125959;
      state       = 4'd3;
      repeat (3) @(negedge clk);
      chk("rst_an", 32'(an), 32'h3F);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_frameDone", 32'(frameDone), 32'd0);

      // Pre-wrap frame shows the zero shadow with the hour blanked; first wrap 24 cycles after release.
      reset  = 1'b0;
      frames = 0;
      run_frame(1'b0, 24'h000000, -1, 24'h0);

      run_frame(1'b1, 24'h125959, -1, 24'h0);
      run_frame(1'b1, 24'h125959, 10, 24'h010000);
      run_frame(1'b1, 24'h010000, 5, 24'h12A959);
      run_frame(1'b1, 24'h12A959, 5, 24'h125A59);

      state = 4'd1;
      repeat (4) run_frame(1'b1, 24'h125A59, -1, 24'h0);

      state = 4'd3;
      repeat (4) run_frame(1'b1, 24'h125A59, -1, 24'h0);

      // Mid-frame async reset at idx 3, prescaler 2.
      repeat (14) @(negedge clk);
      chk("pre_rst_an", 32'(an), 32'h37);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_an", 32'(an), 32'h3F);
      chk("async_rst_seg", 32'(seg), 32'h7F);
      chk("async_rst_dp", 32'(dp), 32'd1);
      chk("async_rst_frameDone", 32'(frameDone), 32'd0);
      repeat (2) @(negedge clk);
      chk("held_rst_an", 32'(an), 32'h3F);
      reset  = 1'b0;
      frames = 0;
      run_frame(1'b0, 24'h000000, -1, 24'h0);
      run_frame(1'b1, 24'h125A59, -1, 24'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
